// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size, NOP word
// and a PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // present a request at PC
    S_WAIT = 2'd1,  // request accepted, waiting for its response
    S_HOLD = 2'd2,  // live instruction presented to IF/ID
    S_DROP = 2'd3   // waiting for a response that must be thrown away
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

  // Instructions are word aligned; the two low address bits are always dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: aligned load on redirect, increment by one instruction,
// asynchronous reset to RESET_PC. Load wins over increment.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  input  logic        inc_i,
  output logic [63:0] pc_o
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  // Next PC: redirect target (aligned), sequential successor (wraps mod 2^64), or hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_pc(load_val_i);
    end else if (inc_i) begin
      pc_d = pc_q + 64'(INSTR_BYTES);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, captures the
// response into the IF/ID-facing registers, stalls on PC_Write=0 and handles
// redirects (including dropping a response already in flight).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PC_Write,
  input  logic        PCSrc,
  input  logic [63:0] Branch_Target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [63:0] PC_Out,
  output logic        Fetch_Valid,
  output logic        Flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [63:0]  pc_out_q, pc_out_d;
  logic         fv_q, fv_d;
  logic         flush_q, flush_d;
  logic         pc_inc;
  logic [63:0]  pc;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (PCSrc),
    .load_val_i(Branch_Target),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  // Next-state and output-register logic; a redirect (PCSrc) beats every other event.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    fv_d     = fv_q;
    flush_d  = PCSrc;
    pc_inc   = 1'b0;
    case (state_q)
      S_REQ: begin
        // A redirect that coincides with acceptance leaves a stale request in flight.
        if (PCSrc) begin
          state_d = imem_ready ? S_DROP : S_REQ;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrc) begin
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          instr_d  = imem_rdata;
          pc_out_d = pc;
          fv_d     = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrc) begin
          fv_d    = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (PC_Write) begin
          pc_inc  = 1'b1;
          fv_d    = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // A further redirect here only reloads the PC; the stale response is still
        // owed, so leave only once it arrives (even in the same cycle as a redirect).
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM and fetch output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_REQ;
      instr_q  <= '0;
      pc_out_q <= '0;
      fv_q     <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      fv_q     <= fv_d;
      flush_q  <= flush_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc;
  assign Instruction = instr_q;
  assign PC_Out      = pc_out_q;
  assign Fetch_Valid = fv_q;
  assign Flush       = flush_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk;
  logic        reset_n;
  logic        PC_Write;
  logic        PCSrc;
  logic [63:0] Branch_Target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic        Fetch_Valid;
  logic        Flush;

  instruction_fetch_unit #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .PC_Write     (PC_Write),
    .PCSrc        (PCSrc),
    .Branch_Target(Branch_Target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC_Out       (PC_Out),
    .Fetch_Valid  (Fetch_Valid),
    .Flush        (Flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fetch is "requesting" whenever nothing is outstanding and
  // no fetched word is being presented.
  logic [63:0] m_pc, m_pcout;
  logic [31:0] m_instr;
  logic        m_out, m_disc, m_fv, m_flush;

  // Memory model: one pending request, response after mem_wait extra cycles.
  logic        mem_busy;
  int          mem_wait;
  logic [31:0] mem_data, last_data;
  int          dly_cfg;     // fixed response delay, or -1 for random 0..3
  bit          spur_en;     // inject unsolicited rvalid when idle
  int          fetch_cnt, flush_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_pcout  = '0;
    m_instr  = '0;
    m_out    = 1'b0;
    m_disc   = 1'b0;
    m_fv     = 1'b0;
    m_flush  = 1'b0;
    mem_busy = 1'b0;
    mem_wait = 0;
  endtask

  task automatic check_model();
    logic m_req;
    m_req = !m_out && !m_fv;
    check_eq("imem_req", 64'(imem_req), 64'(m_req));
    if (m_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("Instruction", 64'(Instruction), 64'(m_instr));
    check_eq("PC_Out", PC_Out, m_pcout);
    check_eq("Fetch_Valid", 64'(Fetch_Valid), 64'(m_fv));
    check_eq("Flush", 64'(Flush), 64'(m_flush));
  endtask

  // Advance the model by one clock using the inputs that were applied this cycle.
  task automatic model_step(input logic rv, input logic [31:0] rd);
    logic acc, resp;
    acc     = !m_out && !m_fv && imem_ready;
    resp    = m_out && rv;
    m_flush = PCSrc;
    if (PCSrc) begin
      m_pc = Branch_Target & ~64'h3;
      if (m_fv) begin
        m_fv    = 1'b0;
        m_instr = 32'h0;
      end
      if (acc) begin
        m_out  = 1'b1;
        m_disc = 1'b1;
      end else if (resp) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
    end else if (acc) begin
      m_out  = 1'b1;
      m_disc = 1'b0;
    end else if (resp) begin
      m_out = 1'b0;
      if (!m_disc) begin
        m_instr = rd;
        m_pcout = m_pc;
        m_fv    = 1'b1;
        fetch_cnt++;
        $display("fetch #%0d pc=%h instr=%h", fetch_cnt, m_pc, rd);
      end
      m_disc = 1'b0;
    end else if (m_fv && PC_Write) begin
      m_pc = m_pc + 64'd4;
      m_fv = 1'b0;
    end
  endtask

  // One clock cycle: drive memory response, check outputs, clock, update models.
  // Called and returns at a falling edge.
  task automatic tick();
    logic        acc, rv;
    logic [31:0] rd;
    if (mem_busy && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data;
    end else begin
      imem_rvalid = !mem_busy && spur_en && ($urandom_range(5) == 0);
      imem_rdata  = $urandom;
    end
    check_model();
    if (Flush) flush_cnt++;
    acc = imem_req && imem_ready;
    rv  = imem_rvalid;
    rd  = imem_rdata;
    @(posedge clk);
    model_step(rv, rd);
    if (rv && mem_busy) begin
      mem_busy  = 1'b0;
      last_data = mem_data;
    end else if (mem_busy && mem_wait > 0) begin
      mem_wait--;
    end
    if (acc) begin
      mem_busy = 1'b1;
      mem_wait = (dly_cfg < 0) ? int'($urandom_range(3)) : dly_cfg;
      mem_data = $urandom;
    end
    @(negedge clk);
  endtask

  initial begin
    int          n;
    int          fc0;
    logic [31:0] snap;
    reset_n       = 1'b0;
    PC_Write      = 1'b1;
    PCSrc         = 1'b0;
    Branch_Target = '0;
    imem_ready    = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    dly_cfg       = 0;
    spur_en       = 1'b0;
    fetch_cnt     = 0;
    flush_cnt     = 0;
    last_data     = '0;
    mem_data      = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_instr", 64'(Instruction), 64'h0);
    check_eq("rst_pcout", PC_Out, 64'h0);
    check_eq("rst_fv", 64'(Fetch_Valid), 64'h0);
    check_eq("rst_flush", 64'(Flush), 64'h0);
    check_eq("rst_addr", imem_addr, RST_PC);
    reset_n = 1'b1;
    $display("scenario: reset release, first fetch");

    // First fetch at 0, then the next request at 4
    tick();
    tick();
    check_eq("s1_fv", 64'(Fetch_Valid), 64'h1);
    check_eq("s1_pcout", PC_Out, 64'h0);
    tick();
    check_eq("s1_req", 64'(imem_req), 64'h1);
    check_eq("s1_addr", imem_addr, 64'h4);

    // Stall 5 cycles in hold
    $display("scenario: stall in hold");
    tick();
    tick();
    PC_Write = 1'b0;
    snap     = last_data;
    repeat (5) begin
      tick();
      check_eq("s2_req", 64'(imem_req), 64'h0);
      check_eq("s2_fv", 64'(Fetch_Valid), 64'h1);
      check_eq("s2_pcout", PC_Out, 64'h4);
      check_eq("s2_instr", 64'(Instruction), 64'(snap));
    end
    PC_Write = 1'b1;
    tick();
    check_eq("s2_req_adv", 64'(imem_req), 64'h1);
    check_eq("s2_addr", imem_addr, 64'h8);

    // Redirect while waiting; response arrives 3 cycles later and is dropped
    $display("scenario: redirect in wait");
    dly_cfg = 3;
    tick();
    PCSrc         = 1'b1;
    Branch_Target = 64'h1003;
    flush_cnt     = 0;
    fc0           = fetch_cnt;
    tick();
    PCSrc = 1'b0;
    check_eq("s3_flush", 64'(Flush), 64'h1);
    n = 0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    check_eq("s3_reach", 64'(imem_req), 64'h1);
    check_eq("s3_addr", imem_addr, 64'h1000);
    check_eq("s3_dropped", 64'(fetch_cnt), 64'(fc0));
    check_eq("s3_flush_cnt", 64'(flush_cnt), 64'h1);

    // Redirect in the same cycle as acceptance
    $display("scenario: redirect with accept");
    dly_cfg       = 1;
    PCSrc         = 1'b1;
    Branch_Target = 64'h2000;
    tick();
    PCSrc   = 1'b0;
    dly_cfg = 0;
    check_eq("s4_req_off", 64'(imem_req), 64'h0);
    n = 0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    check_eq("s4_dropped", 64'(fetch_cnt), 64'(fc0));
    check_eq("s4_reach", 64'(imem_req), 64'h1);
    check_eq("s4_addr", imem_addr, 64'h2000);
    tick();
    tick();
    check_eq("s4_pcout", PC_Out, 64'h2000);

    // Redirect from hold (NOP), redirect in request without ready, then wrap
    $display("scenario: redirect from hold and address wrap");
    PCSrc         = 1'b1;
    imem_ready    = 1'b0;
    Branch_Target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    check_eq("s5_nop", 64'(Instruction), 64'h0);
    check_eq("s5_fv", 64'(Fetch_Valid), 64'h0);
    Branch_Target = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    PCSrc = 1'b0;
    check_eq("s5_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_ready = 1'b1;
    tick();
    tick();
    check_eq("s5_pcout", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check_eq("s5_wrap", imem_addr, 64'h0);

    // Reset asserted while waiting for a response
    $display("scenario: reset during wait");
    PCSrc         = 1'b1;
    imem_ready    = 1'b0;
    Branch_Target = 64'h3000;
    tick();
    PCSrc      = 1'b0;
    imem_ready = 1'b1;
    dly_cfg    = 3;
    tick();
    reset_n     = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_eq("s6_instr", 64'(Instruction), 64'h0);
    check_eq("s6_pcout", PC_Out, 64'h0);
    check_eq("s6_fv", 64'(Fetch_Valid), 64'h0);
    check_eq("s6_flush", 64'(Flush), 64'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_eq("s6_req", 64'(imem_req), 64'h1);
    check_eq("s6_addr", imem_addr, RST_PC);

    // Randomized traffic
    $display("scenario: random traffic");
    dly_cfg = -1;
    spur_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      PC_Write      = ($urandom_range(2) != 0);
      PCSrc         = ($urandom_range(9) == 0);
      Branch_Target = {$urandom, $urandom};
      imem_ready    = ($urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
